// File: rtl/v_latch_arb_pkg.sv
// Shared state encoding and counter sizing for the latch-bank gate arbiter.
package v_latch_arb_pkg;
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    GATE    = 3'd2,
    HOLDOFF = 3'd3,
    CLEAR   = 3'd4
  } state_t;
endpackage

// File: rtl/v_latch_gate_arb_rr_pick.sv
// Combinational round-robin search: first requester at or after ptr, wrapping.
module v_rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic             valid
);
  // Outer loop walks the search order, inner loop keeps every index constant.
  always_comb begin
    pick  = '0;
    valid = 1'b0;
    for (int off = 0; off < N_REQ; off++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!valid && req[j] && (((int'(ptr) + off) % N_REQ) == j)) begin
          pick[j] = 1'b1;
          valid   = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/v_latch_gate_arb.sv
// Arbitrates N_REQ writers and a clear onto one transparent latch bank; G and D registered.
module v_latch_gate_arb
  import v_latch_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int HOLD  = 2
) (
  input  logic                   C,
  input  logic                   R,
  input  logic [N_REQ-1:0]       REQ,
  input  logic [N_REQ*WIDTH-1:0] DIN,
  input  logic                   CLR_REQ,
  output logic                   G,
  output logic [WIDTH-1:0]       D,
  output logic                   CLR,
  output logic [N_REQ-1:0]       GNT,
  output logic [N_REQ-1:0]       ACK,
  output logic                   CLR_ACK,
  output logic                   BUSY
);
  localparam int PTR_W = $clog2(N_REQ);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] nxt_ptr;
  logic [N_REQ-1:0] pick;
  logic             pick_vld;
  logic [WIDTH-1:0] pick_data;

  v_rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
    .req   (REQ),
    .ptr   (ptr),
    .pick  (pick),
    .valid (pick_vld)
  );

  // Pointer holds the next index to search first, so it lands one past the winner.
  always_comb begin
    pick_data = '0;
    nxt_ptr   = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (pick[j]) begin
        pick_data = DIN[j*WIDTH +: WIDTH];
        nxt_ptr   = (j == N_REQ-1) ? '0 : PTR_W'(j + 1);
      end
    end
  end

  always_ff @(posedge C) begin
    if (R) begin
      state   <= IDLE;
      cnt     <= '0;
      ptr     <= '0;
      G       <= 1'b0;
      D       <= '0;
      CLR     <= 1'b0;
      GNT     <= '0;
      ACK     <= '0;
      CLR_ACK <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      ACK     <= '0;
      CLR_ACK <= 1'b0;
      case (state)
        IDLE: begin
          if (CLR_REQ) begin
            state   <= CLEAR;
            CLR     <= 1'b1;
            CLR_ACK <= 1'b1;
            BUSY    <= 1'b1;
          end else if (pick_vld) begin
            state <= SETUP;
            GNT   <= pick;
            D     <= pick_data;
            ptr   <= nxt_ptr;
            BUSY  <= 1'b1;
          end
        end
        SETUP: begin
          state <= GATE;
          G     <= 1'b1;
          cnt   <= CNT_W'(HOLD);
        end
        GATE: begin
          if (cnt == CNT_W'(1)) begin
            state <= HOLDOFF;
            G     <= 1'b0;
            ACK   <= GNT;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        HOLDOFF: begin
          state <= IDLE;
          GNT   <= '0;
          BUSY  <= 1'b0;
        end
        CLEAR: begin
          state <= IDLE;
          CLR   <= 1'b0;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          G     <= 1'b0;
          CLR   <= 1'b0;
          GNT   <= '0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end
endmodule
